// File: rtl/data_memory_responder_if.sv
// Load/store bus between a processor memory stage and the data memory
// responder. The master drives one request at a time; the slave answers
// with a single-cycle ack, optionally qualified by error.
interface data_memory_responder_if;
    logic        req;
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        busy;
    logic        error;

    modport master (
        output req, we, re, addr, wdata,
        input  rdata, ack, busy, error
    );

    modport slave (
        input  req, we, re, addr, wdata,
        output rdata, ack, busy, error
    );
endinterface

// File: rtl/data_memory_responder.sv
// Data memory responder: accepts one word access in IDLE, waits a fixed
// number of wait states, then completes in RESPOND with a one-cycle ack.
// Misaligned, out-of-range and ill-formed commands complete with error and
// leave the array and the read data register untouched.
module data_memory_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_WORDS = 256
) (
    input  logic                    clock,
    input  logic                    reset,
    data_memory_responder_if.slave  bus
);

    localparam int         IDXW     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESPOND
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic        re_q;
    logic [31:0] rdata_q;

    // Storage powers up cleared and is deliberately outside the reset domain.
    logic [31:0] mem_q [DEPTH_WORDS] = '{default: '0};

    // Access fields as seen on the edge that enters RESPOND. With zero wait
    // states that edge is also the accepting edge, so the live bus values
    // must be used because the latches have not been loaded yet.
    logic            in_idle;
    logic [31:0]     eff_addr;
    logic [31:0]     eff_wdata;
    logic            eff_we;
    logic            eff_re;
    logic [IDXW-1:0] eff_idx;
    logic            enter_resp;
    logic            eff_ok;
    logic            wr_en;
    logic            rd_en;

    // An access is rejected when misaligned, beyond the array, or when the
    // command bits are not exactly one of read/write.
    function automatic logic access_fault(input logic [31:0] a, input logic w, input logic r);
        return (a[1:0] != 2'b00) || (|a[31:IDXW+2]) || (w == r);
    endfunction

    // Select live or latched access fields and derive the array strobes.
    always_comb begin
        in_idle    = (state_q == S_IDLE);
        eff_addr   = in_idle ? bus.addr  : addr_q;
        eff_wdata  = in_idle ? bus.wdata : wdata_q;
        eff_we     = in_idle ? bus.we    : we_q;
        eff_re     = in_idle ? bus.re    : re_q;
        eff_idx    = eff_addr[IDXW+1:2];
        enter_resp = (state_d == S_RESPOND) && (state_q != S_RESPOND);
        eff_ok     = !access_fault(eff_addr, eff_we, eff_re);
        wr_en      = enter_resp && eff_ok && eff_we && !reset;
        rd_en      = enter_resp && eff_ok && eff_re;
    end

    // Next-state and wait-state counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = S_RESPOND;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESPOND;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESPOND: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counter and read data register; reset aborts any access.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (rd_en) begin
                rdata_q <= mem_q[eff_idx];
            end
        end
    end

    // Request fields are captured only on acceptance and held while busy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
        end else if (in_idle && bus.req) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            we_q    <= bus.we;
            re_q    <= bus.re;
        end
    end

    // Array write port, committed on the edge entering RESPOND.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[eff_idx] <= eff_wdata;
        end
    end

    // Completion outputs follow the state directly so reset clears them at once.
    always_comb begin
        bus.ack   = (state_q == S_RESPOND);
        bus.busy  = (state_q != S_IDLE);
        bus.error = (state_q == S_RESPOND) && access_fault(addr_q, we_q, re_q);
        bus.rdata = rdata_q;
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: a vector table run through a scoreboard
// on a two-wait-state instance, plus hand sequences for reset abort and the
// zero-wait-state back-to-back case.
module tb_data_memory_responder;

    logic clk;
    logic reset;

    data_memory_responder_if bus();
    data_memory_responder_if bus0();

    data_memory_responder #(.WAIT_CYCLES(2), .DEPTH_WORDS(256)) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus)
    );

    data_memory_responder #(.WAIT_CYCLES(0), .DEPTH_WORDS(256)) dut0 (
        .clock (clk),
        .reset (reset),
        .bus   (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rd;
        string       nm;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rd;
        string       nm;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: every ack on the main instance is matched against the
    // oldest outstanding expectation; error must never show without ack.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.ack) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_ack", 32'(bus.ack), 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    $display("txn %-12s error=%0d rdata=%h", e.nm, bus.error, bus.rdata);
                    chk({e.nm, "_error"}, 32'(bus.error), 32'(e.err));
                    chk({e.nm, "_rdata"}, bus.rdata, e.rd);
                end
            end else begin
                chk("error_without_ack", 32'(bus.error), 32'd0);
            end
        end
    end

    // Drive one access on the two-wait-state instance, scramble the bus
    // while busy, and check the ack latency.
    task automatic do_txn(input logic twe, input logic tre, input logic [31:0] ta,
                          input logic [31:0] tw, input logic exp_err,
                          input logic [31:0] exp_rd, input string nm);
        int   lat;
        exp_t e;
        e.err = exp_err;
        e.rd  = exp_rd;
        e.nm  = nm;
        sb_q.push_back(e);
        bus.req   = 1'b1;
        bus.we    = twe;
        bus.re    = tre;
        bus.addr  = ta;
        bus.wdata = tw;
        @(posedge clk);
        @(negedge clk);
        bus.req   = 1'b0;
        bus.we    = ~twe;
        bus.re    = ~tre;
        bus.addr  = ta ^ 32'h0000_0044;
        bus.wdata = ~tw;
        chk({nm, "_busy"}, 32'(bus.busy), 32'd1);
        lat = 1;
        while (!bus.ack && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_latency"}, 32'(lat), 32'd3);
        @(negedge clk);
    endtask

    vec_t vecs[15];
    vec_t ops0[5];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, "wr_10"};
        vecs[1]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, "rd_10"};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0012, 32'h0,         1'b1, 32'hDEAD_BEEF, "rd_mis_12"};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0400, 32'h1111_1111, 1'b1, 32'hDEAD_BEEF, "wr_oor_400"};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0,         1'b0, 32'h0000_0000, "rd_000"};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_0020, 32'hAAAA_5555, 1'b0, 32'h0000_0000, "wr_20"};
        vecs[6]  = '{1'b1, 1'b1, 32'h0000_0020, 32'hBADB_AD00, 1'b1, 32'h0000_0000, "both_20"};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h0,         1'b0, 32'hAAAA_5555, "rd_20"};
        vecs[8]  = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,         1'b1, 32'hAAAA_5555, "none_20"};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_03FC, 32'hCAFE_F00D, 1'b0, 32'hAAAA_5555, "wr_3fc"};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_03FC, 32'h0,         1'b0, 32'hCAFE_F00D, "rd_3fc"};
        vecs[11] = '{1'b0, 1'b1, 32'h0000_03FD, 32'h0,         1'b1, 32'hCAFE_F00D, "rd_mis_3fd"};
        vecs[12] = '{1'b0, 1'b1, 32'h0000_0400, 32'h0,         1'b1, 32'hCAFE_F00D, "rd_oor_400"};
        vecs[13] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'hCAFE_F00D, "rd_oor_top"};
        vecs[14] = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, "rd_10_again"};

        ops0[0] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0404_0404, 1'b0, 32'h0000_0000, "z_wr_04"};
        ops0[1] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0808_0808, 1'b0, 32'h0000_0000, "z_wr_08"};
        ops0[2] = '{1'b0, 1'b1, 32'h0000_0004, 32'h0,         1'b0, 32'h0404_0404, "z_rd_04"};
        ops0[3] = '{1'b0, 1'b1, 32'h0000_0008, 32'h0,         1'b0, 32'h0808_0808, "z_rd_08"};
        ops0[4] = '{1'b0, 1'b1, 32'h0000_000C, 32'h0,         1'b0, 32'h0000_0000, "z_rd_0c"};

        bus.req = 1'b0;  bus.we = 1'b0;  bus.re = 1'b0;  bus.addr = '0;  bus.wdata = '0;
        bus0.req = 1'b0; bus0.we = 1'b0; bus0.re = 1'b0; bus0.addr = '0; bus0.wdata = '0;

        // Reset state of both instances.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ack",    32'(bus.ack),   32'd0);
        chk("rst_busy",   32'(bus.busy),  32'd0);
        chk("rst_error",  32'(bus.error), 32'd0);
        chk("rst_rdata",  bus.rdata,      32'd0);
        chk("rst0_ack",   32'(bus0.ack),  32'd0);
        chk("rst0_busy",  32'(bus0.busy), 32'd0);
        reset = 1'b0;

        // Vector table; the first access is offered on the first edge out of reset.
        for (int i = 0; i < 15; i++) begin
            do_txn(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata,
                   vecs[i].err, vecs[i].rd, vecs[i].nm);
        end

        // Reset pulsed during WAIT aborts a write to 0x40.
        bus.req = 1'b1; bus.we = 1'b1; bus.re = 1'b0;
        bus.addr = 32'h0000_0040; bus.wdata = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0; bus.we = 1'b0;
        chk("abort_in_wait_busy", 32'(bus.busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_busy",  32'(bus.busy), 32'd0);
        chk("abort_ack",   32'(bus.ack),  32'd0);
        chk("abort_rdata", bus.rdata,     32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("abort_ack_late", 32'(bus.ack), 32'd0);
        reset = 1'b0;
        do_txn(1'b0, 1'b1, 32'h0000_0040, 32'h0, 1'b0, 32'h0000_0000, "rd_40_after");
        do_txn(1'b0, 1'b1, 32'h0000_0010, 32'h0, 1'b0, 32'hDEAD_BEEF, "rd_10_keep");

        // Zero wait states with req held high: ack alternates, busy only in
        // RESPOND, and bus changes during RESPOND are never accepted.
        bus0.req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus0.we    = ops0[i].we;
            bus0.re    = ops0[i].re;
            bus0.addr  = ops0[i].addr;
            bus0.wdata = ops0[i].wdata;
            @(posedge clk);
            @(negedge clk);
            $display("txn %-12s ack=%0d busy=%0d error=%0d rdata=%h",
                     ops0[i].nm, bus0.ack, bus0.busy, bus0.error, bus0.rdata);
            chk({ops0[i].nm, "_ack"},   32'(bus0.ack),   32'd1);
            chk({ops0[i].nm, "_busy"},  32'(bus0.busy),  32'd1);
            chk({ops0[i].nm, "_error"}, 32'(bus0.error), 32'd0);
            chk({ops0[i].nm, "_rdata"}, bus0.rdata,      ops0[i].rd);
            bus0.we    = 1'b1;
            bus0.re    = 1'b0;
            bus0.addr  = 32'h0000_000C;
            bus0.wdata = 32'hFFFF_FFFF;
            @(posedge clk);
            @(negedge clk);
            chk({ops0[i].nm, "_idle_ack"},  32'(bus0.ack),  32'd0);
            chk({ops0[i].nm, "_idle_busy"}, 32'(bus0.busy), 32'd0);
        end
        bus0.req = 1'b0;

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
